// File: rtl/pixel2byte_raw10.sv
// RAW10 pixel-to-byte packer: 4 pixels -> 5 bytes into a byte FIFO, emitted as
// 32-bit payload words with frame-start/end and long-packet requests.
//   state   | meaning
//   S_IDLE  | waiting for a frame-valid rise
//   S_FRAME | inside a frame, between lines
//   S_LINE  | line active, accepting pixel groups
//   S_FLUSH | line closed, draining buffered bytes
module pixel2byte_raw10 #(
  parameter int FIFO_BYTES = 16
) (
  input  logic        core_clk_i,
  input  logic        core_rstn,
  input  logic        pix2byte_rstn_i,
  input  logic        fv_i,
  input  logic        lv_i,
  input  logic        pix_en_i,
  input  logic [39:0] pix_data_i,
  input  logic        ld_pyld_i,
  output logic        sp_req_o,
  output logic        fe_o,
  output logic        lp_req_o,
  output logic [31:0] byte_data_o,
  output logic        byte_data_en_o,
  output logic [15:0] line_wc_o,
  output logic        ovf_o
);

  localparam int CW = $clog2(FIFO_BYTES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_LINE  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_ap;
  logic [7:0]    buf_q [FIFO_BYTES];
  logic [7:0]    buf_d [FIFO_BYTES];
  logic [7:0]    grp_b [5];
  logic          fv_q, lv_q;
  logic          sp_q, sp_d, fe_q, fe_d, lp_q, lp_d, ovf_q, ovf_d;
  logic [15:0]   lcnt_q, lcnt_d, wc_q, wc_d;
  logic          rst, pop_w, push_req, ovf_hit, push_w, in_line;
  int            base_idx;

  assign rst            = ~core_rstn | ~pix2byte_rstn_i;
  assign in_line        = (state_q == S_LINE) || (state_q == S_FLUSH);
  assign byte_data_en_o = (cnt_q >= CW'(4)) || ((state_q == S_FLUSH) && (cnt_q != '0));
  assign lp_req_o       = in_line & (lp_q | byte_data_en_o);
  assign sp_req_o       = sp_q;
  assign fe_o           = fe_q;
  assign line_wc_o      = wc_q;
  assign ovf_o          = ovf_q;

  always_comb begin
    grp_b[0] = pix_data_i[9:2];
    grp_b[1] = pix_data_i[19:12];
    grp_b[2] = pix_data_i[29:22];
    grp_b[3] = pix_data_i[39:32];
    grp_b[4] = {pix_data_i[31:30], pix_data_i[21:20], pix_data_i[11:10], pix_data_i[1:0]};
  end

  // A short final word in FLUSH pops everything that is left.
  always_comb begin
    pop_w    = byte_data_en_o & ld_pyld_i;
    cnt_ap   = cnt_q;
    if (pop_w) cnt_ap = (cnt_q >= CW'(4)) ? cnt_q - CW'(4) : '0;
    push_req = pix_en_i & lv_i & (state_q == S_LINE);
    ovf_hit  = push_req & ((int'(cnt_ap) + 5) > FIFO_BYTES);
    push_w   = push_req & ~ovf_hit;
    cnt_d    = push_w ? cnt_ap + CW'(5) : cnt_ap;
    ovf_d    = ovf_q | ovf_hit;
    base_idx = int'(cnt_ap);
  end

  always_comb begin
    for (int i = 0; i < FIFO_BYTES - 4; i++) buf_d[i] = pop_w ? buf_q[i + 4] : buf_q[i];
    for (int i = FIFO_BYTES - 4; i < FIFO_BYTES; i++) buf_d[i] = pop_w ? 8'h00 : buf_q[i];
    for (int i = 0; i < FIFO_BYTES; i++) begin
      if (push_w && (i >= base_idx) && (i < base_idx + 5)) buf_d[i] = grp_b[3'(i - base_idx)];
    end
  end

  // Bytes above cnt are kept zero, the mask makes the padding explicit.
  always_comb begin
    byte_data_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(cnt_q) > k) byte_data_o[k*8 +: 8] = buf_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = 1'b0;
    fe_d    = fe_q;
    lp_d    = lp_q;
    lcnt_d  = push_w ? lcnt_q + 16'd5 : lcnt_q;
    wc_d    = wc_q;
    case (state_q)
      S_IDLE: begin
        if (fv_i && !fv_q) begin
          sp_d    = 1'b1;
          fe_d    = 1'b0;
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (!fv_i) begin
          sp_d    = 1'b1;
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end else if (lv_i && !lv_q) begin
          lcnt_d  = '0;
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (byte_data_en_o) lp_d = 1'b1;
        if (!lv_i) state_d = S_FLUSH;
      end
      default: begin
        if (byte_data_en_o) lp_d = 1'b1;
        if (cnt_ap == '0) begin
          wc_d    = lcnt_q;
          lp_d    = 1'b0;
          state_d = S_FRAME;
        end
      end
    endcase
  end

  // Edge trackers follow the inputs during clear so a frame already in
  // progress is not mistaken for a fresh rise on release.
  always_ff @(posedge core_clk_i) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fv_q    <= fv_i;
      lv_q    <= lv_i;
      sp_q    <= 1'b0;
      fe_q    <= 1'b0;
      lp_q    <= 1'b0;
      ovf_q   <= 1'b0;
      lcnt_q  <= '0;
      wc_q    <= '0;
      for (int i = 0; i < FIFO_BYTES; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_i;
      lv_q    <= lv_i;
      sp_q    <= sp_d;
      fe_q    <= fe_d;
      lp_q    <= lp_d;
      ovf_q   <= ovf_d;
      lcnt_q  <= lcnt_d;
      wc_q    <= wc_d;
      for (int i = 0; i < FIFO_BYTES; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule
